// File: rtl/midi_byte_parser.sv
// -----------------------------------------------------------------------------
// midi_byte_parser
//   Turns the raw MIDI byte stream from the UART receiver into complete
//   channel and system-common messages, with running-status support. It also
//   separates real-time bytes and sysex payload bytes from the message stream.
//   Every output is registered. A byte that is accepted on a clock edge shows
//   its result from that edge onward, so each strobe is high for exactly one
//   cycle.
//
//   Optional feature: define MIDI_ACTIVE_SENSE_EN to build the active-sense
//   watchdog. Without it, sense_timeout is tied to 0.
//
// Ports:
//   reg_clk        clock, all logic on posedge
//   reset_reg_N    synchronous active-low reset
//   byte_ready     one-cycle strobe, midi_byte valid
//   midi_byte      received byte
//   cur_status     current (running) status byte
//   data1 / data2  data bytes of the last message (data1 also carries sysex payload)
//   msg_valid      one-cycle strobe, message complete
//   rt_valid       one-cycle strobe, real-time byte in rt_byte
//   rt_byte        last real-time byte
//   sysex_valid    one-cycle strobe, sysex payload byte on data1
//   sysex_end      one-cycle strobe, sysex closed by F7 or by another status
//   drop_cnt       saturating count of data bytes dropped while in IDLE
//   sense_timeout  one-cycle strobe, active-sense timeout
// -----------------------------------------------------------------------------
module midi_byte_parser #(
    parameter int DROP_CNT_W    = 8,
    parameter int SENSE_TIMEOUT = 300000
) (
    input  logic                  reg_clk,
    input  logic                  reset_reg_N,
    input  logic                  byte_ready,
    input  logic [7:0]            midi_byte,
    output logic [7:0]            cur_status,
    output logic [6:0]            data1,
    output logic [6:0]            data2,
    output logic                  msg_valid,
    output logic                  rt_valid,
    output logic [7:0]            rt_byte,
    output logic                  sysex_valid,
    output logic                  sysex_end,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  sense_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, SYSEX} state_t;

    state_t                state, state_nxt;
    logic [7:0]            status_nxt, rt_byte_nxt;
    logic [6:0]            d1_nxt, d2_nxt;
    logic [DROP_CNT_W-1:0] drop_nxt;
    logic                  msg_nxt, rt_nxt, sx_nxt, sxe_nxt;

    // Statuses that carry a single data byte: program change, channel
    // pressure, MTC quarter frame and song select.
    function automatic logic one_data(input logic [7:0] s);
        return (s[7:4] == 4'hC) || (s[7:4] == 4'hD) || (s == 8'hF1) || (s == 8'hF3);
    endfunction

`ifdef MIDI_ACTIVE_SENSE_EN
    localparam int CNT_W = (SENSE_TIMEOUT > 1) ? $clog2(SENSE_TIMEOUT) : 1;
    logic [CNT_W-1:0] sense_cnt;
    logic             sense_armed;
    logic             sense_hit;

    // Any received byte restarts the count, so the timeout can only fire
    // on a cycle with no byte.
    assign sense_hit = sense_armed && !byte_ready &&
                       (sense_cnt == CNT_W'(SENSE_TIMEOUT - 1));

    always_ff @(posedge reg_clk) begin
        if (!reset_reg_N) begin
            sense_cnt     <= '0;
            sense_armed   <= 1'b0;
            sense_timeout <= 1'b0;
        end else begin
            sense_timeout <= sense_hit;
            if (byte_ready) begin
                sense_cnt <= '0;
                if (midi_byte == 8'hFE) sense_armed <= 1'b1;
            end else if (sense_hit) begin
                sense_cnt   <= '0;
                sense_armed <= 1'b0;
            end else if (sense_armed) begin
                sense_cnt <= sense_cnt + 1'b1;
            end
        end
    end
`else
    // The timeout parameter is only used when the watchdog is built in.
    logic unused_sense;
    assign unused_sense  = |SENSE_TIMEOUT;
    assign sense_timeout = 1'b0;
`endif

    always_ff @(posedge reg_clk) begin
        if (!reset_reg_N) begin
            state       <= IDLE;
            cur_status  <= '0;
            data1       <= '0;
            data2       <= '0;
            msg_valid   <= 1'b0;
            rt_valid    <= 1'b0;
            rt_byte     <= '0;
            sysex_valid <= 1'b0;
            sysex_end   <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            cur_status  <= status_nxt;
            data1       <= d1_nxt;
            data2       <= d2_nxt;
            msg_valid   <= msg_nxt;
            rt_valid    <= rt_nxt;
            rt_byte     <= rt_byte_nxt;
            sysex_valid <= sx_nxt;
            sysex_end   <= sxe_nxt;
            drop_cnt    <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        status_nxt  = cur_status;
        d1_nxt      = data1;
        d2_nxt      = data2;
        rt_byte_nxt = rt_byte;
        drop_nxt    = drop_cnt;
        msg_nxt     = 1'b0;
        rt_nxt      = 1'b0;
        sx_nxt      = 1'b0;
        sxe_nxt     = 1'b0;

        if (byte_ready) begin
            if (midi_byte >= 8'hF8) begin
                // Real-time bytes pass through and leave the parse state untouched.
                rt_byte_nxt = midi_byte;
                rt_nxt      = 1'b1;
            end else if (midi_byte[7]) begin
                // Any status byte closes an open sysex. The new status is
                // still handled below, so no byte is lost.
                if (state == SYSEX) sxe_nxt = 1'b1;
                if (midi_byte < 8'hF0) begin
                    status_nxt = midi_byte;
                    state_nxt  = WAIT_D1;
                end else begin
                    case (midi_byte[3:0])
                        4'h0: begin
                            status_nxt = midi_byte;
                            state_nxt  = SYSEX;
                        end
                        4'h1, 4'h2, 4'h3: begin
                            status_nxt = midi_byte;
                            state_nxt  = WAIT_D1;
                        end
                        4'h6: begin
                            status_nxt = midi_byte;
                            d1_nxt     = '0;
                            d2_nxt     = '0;
                            msg_nxt    = 1'b1;
                            state_nxt  = IDLE;
                        end
                        4'h4, 4'h5: state_nxt = IDLE;
                        // F7: ends a sysex, otherwise it has no effect.
                        default: if (state == SYSEX) state_nxt = IDLE;
                    endcase
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (drop_cnt != '1) drop_nxt = drop_cnt + 1'b1;
                    end
                    WAIT_D1: begin
                        d1_nxt = midi_byte[6:0];
                        if (one_data(cur_status)) begin
                            d2_nxt    = '0;
                            msg_nxt   = 1'b1;
                            // System common messages do not keep a running status.
                            state_nxt = (cur_status[7:4] == 4'hF) ? IDLE : WAIT_D1;
                        end else begin
                            state_nxt = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        d2_nxt    = midi_byte[6:0];
                        msg_nxt   = 1'b1;
                        state_nxt = (cur_status[7:4] == 4'hF) ? IDLE : WAIT_D1;
                    end
                    SYSEX: begin
                        d1_nxt = midi_byte[6:0];
                        sx_nxt = 1'b1;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end

`ifdef MIDI_ACTIVE_SENSE_EN
        if (sense_hit) begin
            state_nxt = IDLE;
            if (state == SYSEX) sxe_nxt = 1'b1;
        end
`endif
    end

endmodule

// File: doc/midi_byte_parser.md
Name: midi_byte_parser

Overview:
- Upstream stage of the MIDI status decoder; sits between the MIDI UART receiver and the synth controller.
- Assembles the raw serial byte stream into complete channel messages: status, data1 and data2, with running-status support.
- Separates out real-time bytes and sysex payload.
- Drives a stable cur_status/data1/data2 bundle plus a one-cycle msg_valid strobe to the status decoder and controller.

Parameters:
- DROP_CNT_W, 8, width of the saturating dropped-byte counter.
- SENSE_TIMEOUT, 300000, reg_clk cycles without any received byte before an active-sense timeout (used only with the optional feature).

Ports:
- reg_clk  in  1  system register clock; all logic on posedge.
- reset_reg_N  in  1  synchronous active-low reset.
- byte_ready  in  1  one-cycle strobe: midi_byte valid this cycle.
- midi_byte  in  8  received MIDI byte.
- cur_status  out  8  current (running) status byte.
- data1  out  7  first data byte of the last completed message.
- data2  out  7  second data byte (0 for 1-byte messages).
- msg_valid  out  1  one-cycle strobe: channel/common message complete.
- rt_valid  out  1  one-cycle strobe: real-time byte received.
- rt_byte  out  8  last real-time byte (F8..FF).
- sysex_valid  out  1  one-cycle strobe: sysex payload byte on data1.
- sysex_end  out  1  one-cycle strobe: sysex terminated (F7 or abort).
- drop_cnt  out  DROP_CNT_W  saturating count of discarded data bytes.
- sense_timeout  out  1  one-cycle strobe; tied 0 unless the optional feature is compiled in.

Behaviour:
Reset (reset_reg_N=0 at a clock edge):
- All outputs are 0; state is IDLE; running status is invalid.
- Reset mid-message discards any partial bytes.

General:
- Each accepted byte is processed on the edge where byte_ready=1.
- All output strobes rise on the following edge, giving 1-cycle latency, and last exactly one cycle.
- With byte_ready=0, no state changes and all strobes are 0.

Real-time bytes (F8..FF, including FE):
- rt_byte <= byte and rt_valid pulses.
- State, running status and data counters are untouched, in every state including mid-message and SYSEX.

States:
- IDLE: no valid running status.
- WAIT_D1: the status byte has been seen.
- WAIT_D2: data1 has been captured.
- SYSEX: inside a system-exclusive message.

Channel status (80..EF):
- cur_status <= byte; running status becomes valid.
- Next state is WAIT_D1.

Data byte (bit7=0):
- In WAIT_D1 with 1-byte status (Cx, Dx, F1, F3): data1 <= byte, data2 <= 0, msg_valid pulses.
  - Channel status: next state is WAIT_D1 (running status).
  - F1/F3: next state is IDLE.
- In WAIT_D1 with a 2-byte status: data1 <= byte; next state is WAIT_D2.
- In WAIT_D2: data2 <= byte, msg_valid pulses.
  - Channel status: next state is WAIT_D1 (running status).
  - F2: next state is IDLE.
- In IDLE: the byte is discarded and drop_cnt increments, saturating at all-ones.
- In SYSEX: data1 <= byte and sysex_valid pulses.

System common bytes:
- F1, F2, F3: cur_status <= byte; next state is WAIT_D1; running status becomes invalid after completion.
- F6: cur_status <= F6, data1/data2 <= 0, msg_valid pulses; next state is IDLE.
- F4, F5: ignored, go to IDLE, cur_status unchanged.

Sysex:
- F0: cur_status <= F0; next state is SYSEX.
- F7 in SYSEX: sysex_end pulses; next state is IDLE.
- F7 outside SYSEX: ignored.
- Any non-real-time status byte received in SYSEX:
  - sysex_end pulses on the same cycle the new status is taken.
  - The new status is then processed as above; no byte is lost.

Output stability:
- cur_status, data1 and data2 hold their values between updates.
- cur_status never changes in the cycle msg_valid is high, except through the new-status path.
- A status byte arriving in WAIT_D2 abandons the partial message: no msg_valid, and the new status takes effect.

Optional Feature:
Macro: MIDI_ACTIVE_SENSE_EN

Defined:
- Receiving FE arms a counter.
- The counter clears on every byte_ready.
- If the counter reaches SENSE_TIMEOUT-1 while armed:
  - sense_timeout pulses once;
  - the counter disarms and the state goes to IDLE with running status invalid;
  - if in SYSEX, sysex_end also pulses.
- Reset disarms the counter.

Undefined:
- No counter logic; sense_timeout is constant 0.
- FE is treated as any other real-time byte.

Test Plan:
- 90 3C 64 -> msg_valid once, cur_status=90, data1=3C, data2=64; then 3E 00 -> second msg_valid, cur_status=90, data1=3E, data2=00.
- C2 05 07 -> two msg_valid pulses: (C2,05,00) then (C2,07,00).
- 91 40 F8 7F -> rt_valid with rt_byte=F8 between the data bytes; then msg_valid (91,40,7F).
- After reset, 22 33 -> no msg_valid, drop_cnt=2; then F0 01 02 F7 -> two sysex_valid (data1=01, 02), one sysex_end, cur_status=F0.
- F0 11 B0 07 40 -> sysex_valid(11), sysex_end on B0, then msg_valid (B0,07,40); reset asserted after B0 07 -> all outputs 0, next 40 counted in drop_cnt.
- (MIDI_ACTIVE_SENSE_EN, SENSE_TIMEOUT=16) FE then idle 16 cycles -> exactly one sense_timeout pulse; following 40 is dropped (running status cleared).
